// File: rtl/mult_trace_pkg.sv
// Shared types and helpers for the multiplier step trace reader.
//   mul_rec_t  : one captured multiplier step, c1 in the least significant bits.
//   pack_rec() : zero-pads a record to a whole number of 64-bit words.
package mult_trace_pkg;

    localparam int REC_W  = 524;
    localparam int WORD_W = 64;
    localparam int WORDS  = 9;
    localparam int PAD_W  = WORD_W * WORDS;

    // Packed structs place the first member at the MSB, so the fields are
    // listed in reverse to land c1 at bit 0 and i1 at bit 460.
    typedef struct packed {
        logic [63:0] i1;
        logic [63:0] c;
        logic [65:0] c6;
        logic [65:0] c5;
        logic [65:0] c4;
        logic [65:0] c3;
        logic [65:0] c2;
        logic [65:0] c1;
    } mul_rec_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    function automatic logic [PAD_W-1:0] pack_rec(input mul_rec_t rec);
        return {{(PAD_W - REC_W){1'b0}}, rec};
    endfunction

endpackage

// File: rtl/mult_trace_fifo.sv
// Ring buffer of DEPTH multiplier step records.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : synchronous flush of pointers and count (storage kept)
//   push, push_rec : write a record at the tail (ignored when full)
//   pop            : release the head record (ignored when empty)
//   head_rec       : record at the head, read combinationally from storage
//   count          : records held; full / empty flags
module mult_trace_fifo
    import mult_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  mul_rec_t                 push_rec,
    input  logic                     pop,
    output mul_rec_t                 head_rec,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    mul_rec_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (count_reg == (PW + 1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full && !clear;
    assign pop_ok   = pop && !empty && !clear;
    assign count    = count_reg;
    assign head_rec = mem[rd_ptr];

    // Record storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mult_trace_reader.sv
// Captures multiplier step snapshots into a ring buffer and streams each
// record out as nine 64-bit words over a valid/ready handshake.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   clear_i                : flush buffer, read state and drop counter
//   capture_i, c1_i..i1_i  : step strobe and the values to capture
//   rd_valid_o/rd_ready_i  : output handshake; rd_data_o word, rd_last_o on word 8
//   count_o                : records held
//   drop_cnt_o             : saturating count of captures lost to a full buffer
module mult_trace_reader
    import mult_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     capture_i,
    input  logic [65:0]              c1_i,
    input  logic [65:0]              c2_i,
    input  logic [65:0]              c3_i,
    input  logic [65:0]              c4_i,
    input  logic [65:0]              c5_i,
    input  logic [65:0]              c6_i,
    input  logic [63:0]              c_i,
    input  logic [63:0]              i1_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [63:0]              rd_data_o,
    output logic                     rd_last_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    mul_rec_t           cap_rec;
    mul_rec_t           head_rec;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               xfer;
    logic               last_word;
    rd_state_t          state;
    logic [3:0]         widx;
    logic [DROP_W-1:0]  drop_cnt;
    logic [PAD_W-1:0]   head_flat;
    logic [WORD_W-1:0]  words [WORDS];

    assign cap_rec.c1 = c1_i;
    assign cap_rec.c2 = c2_i;
    assign cap_rec.c3 = c3_i;
    assign cap_rec.c4 = c4_i;
    assign cap_rec.c5 = c5_i;
    assign cap_rec.c6 = c6_i;
    assign cap_rec.c  = c_i;
    assign cap_rec.i1 = i1_i;

    assign rd_valid_o = !empty;
    assign xfer       = rd_valid_o && rd_ready_i;
    assign last_word  = (widx == 4'(WORDS - 1));
    assign push       = capture_i && !full && !clear_i;
    assign pop        = xfer && last_word && !clear_i;

    mult_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .clear    (clear_i),
        .push     (push),
        .push_rec (cap_rec),
        .pop      (pop),
        .head_rec (head_rec),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Word serializer: STREAM while any record is held, walking widx 0..8.
    // Leaving STREAM happens only when the last word of the only remaining
    // record goes out with no replacement arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RD_IDLE;
            widx  <= '0;
        end else if (clear_i) begin
            state <= RD_IDLE;
            widx  <= '0;
        end else begin
            case (state)
                RD_IDLE: begin
                    widx <= '0;
                    if (push) begin
                        state <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (xfer) begin
                        if (last_word) begin
                            widx <= '0;
                            if (count == CW'(1) && !push) begin
                                state <= RD_IDLE;
                            end
                        end else begin
                            widx <= widx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= RD_IDLE;
                    widx  <= '0;
                end
            endcase
        end
    end

    // A full buffer loses the capture even if the head record frees a slot
    // in the same cycle; fullness is judged at the start of the cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (clear_i) begin
            drop_cnt <= '0;
        end else if (capture_i && full && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    assign head_flat = pack_rec(head_rec);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign words[gi] = head_flat[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Gating with valid keeps uninitialised storage off the bus after reset.
    assign rd_data_o  = rd_valid_o ? words[widx] : '0;
    assign rd_last_o  = rd_valid_o && last_word;
    assign count_o    = count;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_mult_trace_reader.sv
module tb_mult_trace_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clear;
    logic         capture;
    logic [65:0]  c1, c2, c3, c4, c5, c6;
    logic [63:0]  c, i1;
    logic         rd_valid;
    logic         rd_ready;
    logic [63:0]  rd_data;
    logic         rd_last;
    logic [3:0]   count;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_trace_reader #(
        .DEPTH  (8),
        .DROP_W (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .capture_i  (capture),
        .c1_i       (c1),
        .c2_i       (c2),
        .c3_i       (c3),
        .c4_i       (c4),
        .c5_i       (c5),
        .c6_i       (c6),
        .c_i        (c),
        .i1_i       (i1),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .rd_last_o  (rd_last),
        .count_o    (count),
        .drop_cnt_o (drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference packing written straight from the documented bit offsets.
    function automatic logic [575:0] ref_pack(
        input logic [65:0] a1, input logic [65:0] a2, input logic [65:0] a3,
        input logic [65:0] a4, input logic [65:0] a5, input logic [65:0] a6,
        input logic [63:0] ac, input logic [63:0] ai);
        logic [575:0] v;
        v = '0;
        v[0   +: 66] = a1;
        v[66  +: 66] = a2;
        v[132 +: 66] = a3;
        v[198 +: 66] = a4;
        v[264 +: 66] = a5;
        v[330 +: 66] = a6;
        v[396 +: 64] = ac;
        v[460 +: 64] = ai;
        return v;
    endfunction

    // Tagged record: word 0 = tag (from c1), word 8 = tag (from i1[63:52]).
    task automatic set_rec(input logic [63:0] tag);
        c1 = {2'b00, tag};
        c2 = '0; c3 = '0; c4 = '0; c5 = '0; c6 = '0;
        c  = '0;
        i1 = tag << 52;
    endtask

    task automatic cap(input logic [63:0] tag);
        set_rec(tag);
        capture = 1'b1;
        step;
        capture = 1'b0;
    endtask

    task automatic read_record(input logic [63:0] tag);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (!rd_valid && n < 20) begin
            step;
            n++;
        end
        check_eq("rec_valid", rd_valid, 1);
        for (int w = 0; w < 9; w++) begin
            if (w == 0) begin
                check_eq("rec_w0", rd_data, tag);
                check_eq("rec_last0", rd_last, 0);
            end
            if (w == 8) begin
                check_eq("rec_w8", rd_data, tag);
                check_eq("rec_last8", rd_last, 1);
            end
            step;
        end
        $display("read record tag=%0d", tag);
    endtask

    logic [575:0] exp_bp;
    logic [63:0]  exp_single [9];
    logic [15:0]  pat;
    int           xfers;
    int           cyc;

    initial begin
        clear = 1'b0; capture = 1'b0; rd_ready = 1'b0;
        set_rec(0);

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step;
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_data", rd_data, 0);
        check_eq("rst_last", rd_last, 0);

        // Single record with hand-computed words
        exp_single[0] = 64'h1;
        exp_single[1] = 64'h3;
        for (int k = 2; k < 8; k++) exp_single[k] = 64'h0;
        exp_single[8] = 64'hFFF;
        c1 = 66'h3_0000_0000_0000_0001;
        c2 = '0; c3 = '0; c4 = '0; c5 = '0; c6 = '0; c = '0;
        i1 = 64'hFFF0_0000_0000_0000;
        rd_ready = 1'b1;
        capture = 1'b1;
        step;
        capture = 1'b0;
        for (int w = 0; w < 9; w++) begin
            check_eq("single_valid", rd_valid, 1);
            check_eq("single_data", rd_data, exp_single[w]);
            check_eq("single_last", rd_last, (w == 8) ? 64'd1 : 64'd0);
            step;
        end
        $display("read single record");
        check_eq("single_end_valid", rd_valid, 0);
        check_eq("single_end_count", count, 0);

        // Overflow: 10 captures into 8 slots
        rd_ready = 1'b0;
        for (int k = 0; k < 10; k++) cap(64'(k));
        check_eq("ovf_count", count, 8);
        check_eq("ovf_drop", drop_cnt, 2);
        for (int k = 0; k < 8; k++) read_record(64'(k));
        check_eq("ovf_drained", count, 0);

        // Second and third fills; the third crosses the pointer wrap
        rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) cap(64'(20 + k));
        check_eq("fill2_count", count, 5);
        for (int k = 0; k < 5; k++) read_record(64'(20 + k));
        rd_ready = 1'b0;
        for (int k = 0; k < 6; k++) cap(64'(30 + k));
        check_eq("fill3_count", count, 6);
        for (int k = 0; k < 6; k++) read_record(64'(30 + k));
        check_eq("fill3_drained", rd_valid, 0);

        // Backpressure with a fixed ready pattern
        rd_ready = 1'b0;
        c1 = 66'h2_0123_4567_89AB_CDEF;
        c2 = 66'h1_1111_2222_3333_4444;
        c3 = 66'h3_5555_6666_7777_8888;
        c4 = 66'h0_9999_AAAA_BBBB_CCCC;
        c5 = 66'h2_DDDD_EEEE_FFFF_0000;
        c6 = 66'h1_1357_9BDF_2468_ACE0;
        c  = 64'hCAFE_BABE_DEAD_BEEF;
        i1 = 64'hFEDC_BA98_7654_3210;
        exp_bp = ref_pack(c1, c2, c3, c4, c5, c6, c, i1);
        capture = 1'b1;
        step;
        capture = 1'b0;
        pat = 16'b0110_1001_1100_0101;
        xfers = 0;
        cyc = 0;
        while (xfers < 9 && cyc < 40) begin
            rd_ready = pat[cyc % 16];
            check_eq("bp_data", rd_data, exp_bp[xfers*64 +: 64]);
            check_eq("bp_last", rd_last, (xfers == 8) ? 64'd1 : 64'd0);
            step;
            if (rd_ready) xfers++;
            cyc++;
        end
        $display("read backpressured record in %0d cycles", cyc);
        check_eq("bp_xfers", 64'(xfers), 9);
        check_eq("bp_end_valid", rd_valid, 0);

        // Capture colliding with the final-word pop, count 1
        rd_ready = 1'b0;
        cap(50);
        rd_ready = 1'b1;
        repeat (8) step;
        check_eq("coll1_last", rd_last, 1);
        set_rec(51);
        capture = 1'b1;
        step;
        capture = 1'b0;
        check_eq("coll1_count", count, 1);
        check_eq("coll1_w0", rd_data, 51);
        check_eq("coll1_last0", rd_last, 0);
        read_record(51);
        check_eq("coll1_end", count, 0);

        // Same collision with a full buffer: capture dropped
        rd_ready = 1'b0;
        for (int k = 0; k < 8; k++) cap(64'(40 + k));
        check_eq("coll8_full", count, 8);
        rd_ready = 1'b1;
        repeat (8) step;
        check_eq("coll8_last", rd_last, 1);
        set_rec(99);
        capture = 1'b1;
        step;
        capture = 1'b0;
        check_eq("coll8_count", count, 7);
        check_eq("coll8_drop", drop_cnt, 3);
        for (int k = 1; k < 8; k++) read_record(64'(40 + k));
        check_eq("coll8_end", count, 0);

        // Flush mid-record with a concurrent capture
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) cap(64'(60 + k));
        rd_ready = 1'b1;
        repeat (4) step;
        set_rec(63);
        capture = 1'b1;
        clear = 1'b1;
        step;
        capture = 1'b0;
        clear = 1'b0;
        check_eq("clr_count", count, 0);
        check_eq("clr_valid", rd_valid, 0);
        check_eq("clr_drop", drop_cnt, 0);
        check_eq("clr_data", rd_data, 0);
        step;
        check_eq("clr_no_capture", count, 0);
        cap(64);
        read_record(64);

        // Asynchronous reset mid-record
        rd_ready = 1'b0;
        for (int k = 0; k < 9; k++) cap(64'(70 + k));
        check_eq("arst_pre_drop", drop_cnt, 1);
        rd_ready = 1'b1;
        repeat (4) step;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", rd_valid, 0);
        check_eq("arst_count", count, 0);
        check_eq("arst_drop", drop_cnt, 0);
        check_eq("arst_data", rd_data, 0);
        check_eq("arst_last", rd_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step;
        check_eq("arst_after_valid", rd_valid, 0);
        cap(80);
        read_record(80);
        check_eq("arst_end", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_trace_reader.md
Name: mult_trace_reader

Overview:
- Synthesizable readback end for multiplier step snapshots in the ECC accelerator (CVXIF example).
- On each multiplication step strobe, captures the operand/partial-product set {c1..c6, c, i1} into an on-chip ring buffer.
- A debug or CSR side then drains the records as a stream of 64-bit words over a valid/ready handshake.
- Replaces file-based tracing with a path that exists in silicon and in any simulator.

Parameters:
- DEPTH, 8, number of buffered records; must be a power of two, >= 2.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- clear_i  input  1  synchronous flush of the buffer, read state and drop counter.
- capture_i  input  1  multiplication step strobe (mul_start).
- c1_i..c6_i  input  66 each  partial products.
- c_i  input  64  carry/accumulator word.
- i1_i  input  64  step operand.
- rd_valid_o  output  1  word available.
- rd_ready_i  input  1  consumer accepts the word.
- rd_data_o  output  64  current record word.
- rd_last_o  output  1  current word is the last word (word 8) of its record.
- count_o  output  $clog2(DEPTH)+1  records held.
- drop_cnt_o  output  DROP_W  records dropped because the buffer was full.

Behaviour:
- Reset (async, rst_ni=0):
  - rd_valid_o=0, rd_last_o=0, rd_data_o=0, count_o=0, drop_cnt_o=0.
  - wr_ptr=rd_ptr=0, word index widx=0.
  - Record storage is not reset.
- Record packing (524 bits, LSB first):
  - c1[65:0]@0, c2@66, c3@132, c4@198, c5@264, c6@330, c@396, i1@460.
  - Zero-padded to 576 bits; 9 words. Word k = bits[64k+63:64k].
  - Word 8 = {52'b0, i1[63:52]}.
- Capture:
  - Accepted when capture_i=1 and count_o < DEPTH, both evaluated at the start of the cycle.
  - Record is written at wr_ptr; wr_ptr advances modulo DEPTH.
  - If count_o == DEPTH, the record is dropped and drop_cnt_o increments, saturating at all-ones. This holds even if the final word of the head record pops in the same cycle.
- Read side:
  - rd_valid_o = (count_o != 0).
  - rd_data_o = word[widx] of entry rd_ptr; combinational mux from registered storage.
  - rd_last_o = rd_valid_o && widx==8.
  - Transfer on rd_valid_o && rd_ready_i: widx increments.
  - On the transfer with widx==8: widx returns to 0, rd_ptr advances modulo DEPTH, count decrements.
  - While rd_valid_o=1 and rd_ready_i=0, rd_data_o and rd_last_o hold stable.
- Latency: a record captured in cycle N shows rd_valid_o=1 with word 0 in cycle N+1 if the buffer was empty.
- Simultaneous accepted capture and final-word pop: count_o unchanged; pointers both advance.
- Wrap-around: pointers are $clog2(DEPTH) bits; count distinguishes full from empty.
- Read FSM:
  - IDLE (count==0): widx held at 0.
  - STREAM (count!=0): walks widx 0..8 per record.
  - Returns to IDLE after the last word of the last record.
- clear_i has priority over capture and pop.
  - Next cycle: count_o=0, pointers=0, widx=0, drop_cnt_o=0, rd_valid_o=0.
  - A capture in the same cycle is discarded and not counted as a drop.
- Async reset mid-stream abandons the partial record; no stale word is presented afterwards.

Decomposition:
- Package mult_trace_pkg:
  - REC_W=524, WORD_W=64, WORDS=9.
  - Typedef mul_rec_t: packed struct in the bit order above.
  - Function pack_rec(), returning a 576-bit padded vector.
- Sub-module mult_trace_fifo: DEPTH x mul_rec_t ring buffer with push/pop, count, full/empty.
- The top holds the word serializer FSM and the drop counter.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles, then release -> rd_valid_o=0, count_o=0, drop_cnt_o=0, rd_data_o=0.
- Single record: capture with c1=66'h3_0000_0000_0000_0001, c2..c6=0, c=0, i1=64'hFFF0_0000_0000_0000, rd_ready_i=1.
  - Next cycle: word0=64'h1, word1=64'h3, words2..7=0, word8=64'hFFF with rd_last_o=1.
  - Then rd_valid_o=0 and count_o=0.
- Overflow: 10 captures with i1=0..9 while rd_ready_i=0 -> count_o=8, drop_cnt_o=2.
  - Then drain -> word-8 tags appear in order, i1 0..7; the buffer wraps correctly on a second fill.
- Backpressure: toggle rd_ready_i pseudo-randomly during a record.
  - rd_data_o is stable while not accepted.
  - Exactly 9 transfers; rd_last_o only on the 9th.
- Simultaneous events:
  - count_o=1; capture in the same cycle as the word-8 transfer -> count_o stays 1, next cycle word 0 of the new record.
  - With count_o=8, the same collision -> new record dropped, drop_cnt_o+1.
- Flush and reset:
  - clear_i pulsed at widx=4 with 3 records held and a concurrent capture -> next cycle count_o=0, rd_valid_o=0, drop_cnt_o=0.
  - Repeat with rst_ni asserted mid-cycle -> outputs go to reset values immediately.
